// File: rtl/imem_pkg.sv
// Shared types and default sizes for the instruction-memory port arbiter.
package imem_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_e;

  typedef enum logic {
    GNT_FETCH,
    GNT_LOADER
  } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant (fetch vs loader). While run is low, only the
// loader can be granted.
import imem_pkg::*;

module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic fetch_req,
  input  logic ld_req,
  output logic fetch_gnt,
  output logic ld_gnt
);

  grant_e last_grant;

  // NOTE: every output of an always_comb block gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!run) begin
      ld_gnt = ld_req;
    end else if (fetch_req && ld_req) begin
      if (last_grant == GNT_LOADER) fetch_gnt = 1'b1;
      else                          ld_gnt    = 1'b1;
    end else begin
      fetch_gnt = fetch_req;
      ld_gnt    = ld_req;
    end
  end

  // A grant is only ever given to a valid requester, so every grant is an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst)            last_grant <= GNT_LOADER;
    else if (ld_gnt)    last_grant <= GNT_LOADER;
    else if (fetch_gnt) last_grant <= GNT_FETCH;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a single-ported, 1-cycle-latency instruction memory between fetch
// and the program loader, and holds fetch off until the loader signals done.
import imem_pkg::*;

module imem_port_arbiter #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rsp_valid,
  output logic [DATA_W-1:0] fetch_rsp_data,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_rsp_valid,
  output logic [DATA_W-1:0] ld_rsp_data,
  input  logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_active,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int unsigned      WORDS_MAX_I = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] WORDS_MAX   = WORDS_MAX_I[CNT_W-1:0];

  state_e            state;
  logic              fetch_gnt;
  logic              ld_gnt;
  logic              ld_rd;
  logic              ld_wr;
  logic [DATA_W-1:0] fetch_hold;
  logic [DATA_W-1:0] ld_hold;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .run       (state == ST_RUN),
    .fetch_req (fetch_req_valid),
    .ld_req    (ld_req_valid),
    .fetch_gnt (fetch_gnt),
    .ld_gnt    (ld_gnt)
  );

  assign fetch_req_ready = fetch_gnt;
  assign ld_req_ready    = ld_gnt;
  assign ld_rd           = ld_gnt & ~ld_we;
  assign ld_wr           = ld_gnt & ld_we;

  always_comb begin
    mem_en    = fetch_gnt | ld_gnt;
    mem_we    = ld_wr;
    mem_addr  = ld_gnt ? ld_addr : fetch_addr;
    mem_wdata = ld_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      boot_active <= 1'b1;
    end else if (state == ST_BOOT && ld_done) begin
      state       <= ST_RUN;
      boot_active <= 1'b0;
    end
  end

  // Read data comes straight from the memory in the response cycle; the hold
  // registers keep the last delivered word visible while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_rsp_valid <= 1'b0;
      ld_rsp_valid    <= 1'b0;
      fetch_hold      <= '0;
      ld_hold         <= '0;
    end else begin
      fetch_rsp_valid <= fetch_gnt;
      ld_rsp_valid    <= ld_rd;
      if (fetch_rsp_valid) fetch_hold <= mem_rdata;
      if (ld_rsp_valid)    ld_hold    <= mem_rdata;
    end
  end

  assign fetch_rsp_data = fetch_rsp_valid ? mem_rdata : fetch_hold;
  assign ld_rsp_data    = ld_rsp_valid    ? mem_rdata : ld_hold;

  always_ff @(posedge clk) begin
    if (rst)                                 words_loaded <= '0;
    else if (ld_wr && words_loaded != WORDS_MAX) words_loaded <= words_loaded + 1'b1;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomised scoreboard bench for imem_port_arbiter with a behavioural
// memory and a high-level reference model of boot, grants and responses.
module tb_imem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req_valid = 1'b0;
  logic          fetch_req_ready;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_rsp_valid;
  logic [DW-1:0] fetch_rsp_data;
  logic          ld_req_valid = 1'b0;
  logic          ld_req_ready;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_rsp_valid;
  logic [DW-1:0] ld_rsp_data;
  logic          ld_done = 1'b0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          boot_active;
  logic [CW-1:0] words_loaded;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_addr      (fetch_addr),
    .fetch_rsp_valid (fetch_rsp_valid),
    .fetch_rsp_data  (fetch_rsp_data),
    .ld_req_valid    (ld_req_valid),
    .ld_req_ready    (ld_req_ready),
    .ld_we           (ld_we),
    .ld_addr         (ld_addr),
    .ld_wdata        (ld_wdata),
    .ld_rsp_valid    (ld_rsp_valid),
    .ld_rsp_data     (ld_rsp_data),
    .ld_done         (ld_done),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .boot_active     (boot_active),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with 1-cycle read latency.
  logic [DW-1:0] imem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) imem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= imem[mem_addr];
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          fq[$];
  rsp_t          lq[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  bit            mon_on  = 1'b0;

  // Reference model state.
  bit            m_run;
  bit            m_last_loader;
  int            m_words;
  logic [DW-1:0] m_ref [64];
  logic [DW-1:0] m_fetch_last;
  logic [DW-1:0] m_ld_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run         = 1'b0;
    m_last_loader = 1'b1;
    m_words       = 0;
    m_fetch_last  = '0;
    m_ld_last     = '0;
    fq.delete();
    lq.delete();
  endtask

  // One clock cycle: compare the cycle's combinational outputs against the
  // model, predict responses, then advance the model across the edge.
  task automatic tick();
    bit eg_f, eg_l, do_rst;
    @(negedge clk);
    eg_f = 1'b0;
    eg_l = 1'b0;
    if (!m_run) eg_l = ld_req_valid;
    else if (fetch_req_valid && ld_req_valid) begin
      if (m_last_loader) eg_f = 1'b1;
      else               eg_l = 1'b1;
    end else begin
      eg_f = fetch_req_valid;
      eg_l = ld_req_valid;
    end
    check("fetch_req_ready", 64'(fetch_req_ready), 64'(eg_f));
    check("ld_req_ready", 64'(ld_req_ready), 64'(eg_l));
    check("mem_en", 64'(mem_en), 64'(eg_f | eg_l));
    check("mem_we", 64'(mem_we), 64'(eg_l & ld_we));
    check("boot_active", 64'(boot_active), 64'(!m_run));
    check("words_loaded", 64'(words_loaded), 64'(m_words));
    if (eg_f) check("mem_addr_fetch", 64'(mem_addr), 64'(fetch_addr));
    if (eg_l) check("mem_addr_ld", 64'(mem_addr), 64'(ld_addr));
    if (eg_l && ld_we) check("mem_wdata", 64'(mem_wdata), 64'(ld_wdata));

    if (eg_f) fq.push_back('{cyc + 1, m_ref[fetch_addr]});
    if (eg_l) begin
      if (ld_we) begin
        m_ref[ld_addr] = ld_wdata;
        if (m_words < 64) m_words++;
      end else begin
        lq.push_back('{cyc + 1, m_ref[ld_addr]});
      end
    end
    if (eg_f || eg_l) m_last_loader = eg_l;
    if (!m_run && ld_done) m_run = 1'b1;
    do_rst = rst;

    @(posedge clk);
    cyc++;
    if (do_rst) model_reset();
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req_valid = 1'b0;
    ld_req_valid    = 1'b0;
    ld_we           = 1'b0;
    ld_done         = 1'b0;
  endtask

  // Response monitor: pops a prediction whenever the DUT presents a response.
  always @(negedge clk) begin
    if (mon_on) begin
      rsp_t e;
      if (fetch_rsp_valid) begin
        if (fq.size() == 0) check("fetch_rsp_unexpected", 64'(1), 64'(0));
        else begin
          e = fq.pop_front();
          check("fetch_rsp_cycle", 64'(cyc), 64'(e.due));
          check("fetch_rsp_data", 64'(fetch_rsp_data), 64'(e.data));
          m_fetch_last = e.data;
        end
      end else begin
        if (fq.size() > 0 && fq[0].due <= cyc) begin
          check("fetch_rsp_missing", 64'(0), 64'(1));
          e = fq.pop_front();
        end
        check("fetch_rsp_hold", 64'(fetch_rsp_data), 64'(m_fetch_last));
      end
      if (ld_rsp_valid) begin
        if (lq.size() == 0) check("ld_rsp_unexpected", 64'(1), 64'(0));
        else begin
          e = lq.pop_front();
          check("ld_rsp_cycle", 64'(cyc), 64'(e.due));
          check("ld_rsp_data", 64'(ld_rsp_data), 64'(e.data));
          m_ld_last = e.data;
        end
      end else begin
        if (lq.size() > 0 && lq[0].due <= cyc) begin
          check("ld_rsp_missing", 64'(0), 64'(1));
          e = lq.pop_front();
        end
        check("ld_rsp_hold", 64'(ld_rsp_data), 64'(m_ld_last));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      imem[i]  = '0;
      m_ref[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // Boot lockout: fetch is held off while the loader owns memory.
    fetch_req_valid = 1'b1;
    fetch_addr      = 6'd5;
    repeat (10) tick();
    idle_inputs();

    // Image load over 64 consecutive cycles, then one saturating write.
    for (int i = 0; i < 64; i++) begin
      ld_req_valid = 1'b1;
      ld_we        = 1'b1;
      ld_addr      = AW'(i);
      ld_wdata     = 32'h13 + 32'(i);
      tick();
    end
    ld_addr  = 6'd0;
    ld_wdata = 32'h13;
    tick();

    // Boot exit together with a final write.
    ld_done  = 1'b1;
    ld_addr  = 6'd3;
    ld_wdata = 32'h16;
    tick();
    idle_inputs();

    fetch_req_valid = 1'b1;
    fetch_addr      = 6'd3;
    tick();
    idle_inputs();
    tick();

    // Contention: fetch and loader reads alternate, fetch first.
    fetch_req_valid = 1'b1;
    fetch_addr      = 6'd1;
    ld_req_valid    = 1'b1;
    ld_we           = 1'b0;
    ld_addr         = 6'd2;
    repeat (4) tick();
    idle_inputs();
    tick();

    // Streaming fetch reads.
    for (int a = 10; a < 14; a++) begin
      fetch_req_valid = 1'b1;
      fetch_addr      = AW'(a);
      tick();
    end
    idle_inputs();
    tick();

    // Randomised traffic in run mode; ld_done must have no effect here.
    for (int i = 0; i < 300; i++) begin
      fetch_req_valid = 1'($urandom_range(0, 1));
      fetch_addr      = AW'($urandom);
      ld_req_valid    = 1'($urandom_range(0, 1));
      ld_we           = 1'($urandom_range(0, 1));
      ld_addr         = AW'($urandom);
      ld_wdata        = $urandom;
      ld_done         = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
    tick();

    // Reset lands on the edge right after a fetch read is accepted.
    fetch_req_valid = 1'b1;
    fetch_addr      = 6'd7;
    rst             = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();

    // Back in boot: fetch locked out, loader traffic counts again.
    for (int i = 0; i < 30; i++) begin
      fetch_req_valid = 1'($urandom_range(0, 1));
      fetch_addr      = AW'($urandom);
      ld_req_valid    = 1'($urandom_range(0, 1));
      ld_we           = 1'($urandom_range(0, 1));
      ld_addr         = AW'($urandom);
      ld_wdata        = $urandom;
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    check("fetch_queue_drained", 64'(fq.size()), 64'(0));
    check("ld_queue_drained", 64'(lq.size()), 64'(0));
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-ported, word-addressed instruction memory between two requesters: the fetch path (read-only) and the program loader (read/write, boot-time image load and debug readback).
- Owns the boot sequencing. After reset only the loader may access memory. Fetch is enabled once the loader signals completion.
- Sits between the fetch stage, the loader, and a clocked instruction memory with 1-cycle read latency.

Parameters:
- ADDR_W, 6, word address width (64 words)
- DATA_W, 32, instruction word width
- CNT_W, 7, width of the words_loaded counter (must hold 2**ADDR_W)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req_valid  in  1  fetch read request
- fetch_req_ready  out  1  fetch request accepted this cycle
- fetch_addr  in  ADDR_W  fetch word address
- fetch_rsp_valid  out  1  fetch read data valid (1-cycle pulse)
- fetch_rsp_data  out  DATA_W  fetch read data
- ld_req_valid  in  1  loader request
- ld_req_ready  out  1  loader request accepted this cycle
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_rsp_valid  out  1  loader read data valid (reads only)
- ld_rsp_data  out  DATA_W  loader read data
- ld_done  in  1  loader image complete; ends boot
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we = 0
- boot_active  out  1  high while in ST_BOOT; drives the core stall
- words_loaded  out  CNT_W  count of accepted loader writes, saturating

Behaviour:
- Reset (rst = 1 at a clock edge) sets:
  - state = ST_BOOT, boot_active = 1
  - last_grant = LOADER
  - both rsp_valid = 0, both rsp_data = 0
  - words_loaded = 0
  - any in-flight read response is dropped.
- Handshake: a request transfers when valid && ready in the same cycle.
  - ready is combinational from the grant decision and never depends on the requester's own ready.
  - At most one grant per cycle.
- mem_en = 1 only in a cycle with an accepted request. mem_addr, mem_we and mem_wdata are muxed combinationally from the granted requester. When idle, mem_en = 0 and mem_we = 0.
- ST_BOOT:
  - fetch_req_ready = 0.
  - ld_req_ready = ld_req_valid.
  - ld_done = 1 moves the state to ST_RUN at the next edge. A loader request in the same cycle is still accepted.
- ST_RUN:
  - Round-robin between the requesters.
  - A single requester is granted immediately.
  - When both request, the one not in last_grant wins.
  - last_grant updates only on an accepted request.
  - ld_done is ignored. ST_RUN is left only by reset.
- Latency:
  - A read accepted in cycle N gives rsp_valid = 1 in N+1, with rsp_data = mem_rdata, on the requester that issued it.
  - Writes produce no response.
  - No response backpressure: requesters must sink the pulse.
  - rsp_data holds its last value while rsp_valid = 0.
- Back-to-back: a new read may be accepted every cycle, so rsp_valid can stay high for consecutive cycles.
- words_loaded increments on each accepted loader write in either state and saturates at 2**ADDR_W. Loader reads do not count.
- Address wrap is not an issue: the address is ADDR_W bits and there is no increment inside the block.
- Reset while a read is in flight: no rsp_valid in the following cycle.

Decomposition:
- Package imem_pkg holds:
  - IMEM_ADDR_W = 6, IMEM_DATA_W = 32
  - state enum {ST_BOOT, ST_RUN}
  - grant enum {GNT_FETCH, GNT_LOADER}
- One sub-module, rr_arb2: 2-input round-robin grant logic with a last_grant register and an enable input that forces loader-only grant during boot.
- The response-routing register and words_loaded counter stay in the top.

Test Plan:
- Boot lockout: rst, then fetch_req_valid = 1, fetch_addr = 5 for 10 cycles → fetch_req_ready = 0 throughout, mem_en = 0, boot_active = 1.
- Image load: loader writes addresses 0..63 with data 0x00000013 + addr over 64 consecutive cycles → mem_we = 1 each cycle, words_loaded = 64. One further write keeps words_loaded = 64.
- Boot exit: ld_done pulse together with a write to address 3 → write performed, boot_active = 0 next cycle. Fetch read of address 3 then gives fetch_rsp_valid one cycle later with data 0x00000016.
- Contention: in ST_RUN, both assert reads (fetch addr 1, loader addr 2) for 4 cycles with last_grant = LOADER → grants alternate F, L, F, L. Each rsp_valid pulses one cycle after its grant with the correct word.
- Streaming: fetch alone reads addresses 10..13 back-to-back → ready = 1 each cycle, fetch_rsp_valid high for 4 consecutive cycles, data in order.
- Reset mid-read: fetch read accepted in cycle N with rst = 1 at edge N+1 → fetch_rsp_valid = 0 at N+1, state ST_BOOT, words_loaded = 0.
